// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from an 8-bit FIFO and packs them little-endian
// into DATA_WIDTH-bit words on a valid/ready stream. A flush pulse closes the
// current partial word (zero-padded, byte count attached, out_last set).
module fifo_word_packer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    input  logic [7:0]                        fifo_rdata,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [$clog2(DATA_WIDTH/8):0]     out_bytes,
    output logic                              out_last
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES) + 1;

    // cnt == FULL_CNT marks the HOLD state: asm is complete but the output
    // register is still occupied, so the word waits in asm.
    localparam logic [CW-1:0] FULL_CNT  = CW'(BYTES);
    localparam logic [CW-1:0] LAST_LANE = CW'(BYTES - 1);
    localparam logic [CW:0]   FULL_EXT  = (CW + 1)'(BYTES);

    // Assembly side
    logic [DATA_WIDTH-1:0] asm_word;
    logic [DATA_WIDTH-1:0] asm_word_nxt;
    logic [DATA_WIDTH-1:0] asm_merged;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  pend;
    logic                  flush_pend;
    logic                  flush_pend_nxt;

    // Output register next values
    logic                  out_valid_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [CW-1:0]         out_bytes_nxt;
    logic                  out_last_nxt;

    logic                  out_free;
    logic                  in_hold;
    logic                  completing;

    // The output register can take a new word when empty or draining this edge.
    assign out_free   = !out_valid || out_ready;
    assign in_hold    = (cnt == FULL_CNT);
    assign completing = pend && (cnt == LAST_LANE);

    // A pop is only issued when a free lane is guaranteed for its byte, counting
    // the byte already in flight; a pending flush freezes the FIFO side.
    assign fifo_rd_en = !fifo_empty && !flush_pend &&
                        (({1'b0, cnt} + {{CW{1'b0}}, pend}) < FULL_EXT);

    // Merge the arriving byte into lane cnt of the assembly word.
    always_comb begin
        asm_merged = asm_word;
        for (int k = 0; k < BYTES; k++) begin
            if (pend && (cnt == CW'(k))) begin
                asm_merged[8*k +: 8] = fifo_rdata;
            end
        end
    end

    // Next-state: byte capture, word completion / HOLD release, flush service.
    always_comb begin
        asm_word_nxt   = asm_word;
        cnt_nxt        = cnt;
        flush_pend_nxt = flush_pend;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        out_bytes_nxt  = out_bytes;
        out_last_nxt   = out_last;

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (in_hold) begin
            // A full word parked in asm moves out as soon as the register frees.
            // A flush that arrived meanwhile is satisfied by this same word.
            if (out_free) begin
                out_valid_nxt  = 1'b1;
                out_data_nxt   = asm_word;
                out_bytes_nxt  = FULL_CNT;
                out_last_nxt   = flush_pend;
                flush_pend_nxt = 1'b0;
                asm_word_nxt   = '0;
                cnt_nxt        = '0;
            end
        end else if (completing) begin
            if (out_free) begin
                out_valid_nxt  = 1'b1;
                out_data_nxt   = asm_merged;
                out_bytes_nxt  = FULL_CNT;
                out_last_nxt   = flush_pend;
                flush_pend_nxt = 1'b0;
                asm_word_nxt   = '0;
                cnt_nxt        = '0;
            end else begin
                asm_word_nxt = asm_merged;
                cnt_nxt      = FULL_CNT;
            end
        end else if (pend) begin
            asm_word_nxt = asm_merged;
            cnt_nxt      = cnt + CW'(1);
        end else if (flush_pend && out_free) begin
            // Nothing in flight: close the partial word, or just drop the
            // request when there is nothing to send.
            if (cnt != '0) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = asm_word;
                out_bytes_nxt = cnt;
                out_last_nxt  = 1'b1;
                asm_word_nxt  = '0;
                cnt_nxt       = '0;
            end
            flush_pend_nxt = 1'b0;
        end

        // A flush seen while one is already pending is absorbed.
        if (flush && !flush_pend) begin
            flush_pend_nxt = 1'b1;
        end
    end

    // State and output registers; reset discards any in-flight byte and partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_word   <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
            out_last   <= 1'b0;
        end else begin
            asm_word   <= asm_word_nxt;
            cnt        <= cnt_nxt;
            pend       <= fifo_rd_en;
            flush_pend <= flush_pend_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_bytes  <= out_bytes_nxt;
            out_last   <= out_last_nxt;
        end
    end

endmodule
